// File: rtl/riscv_lsu_if.sv
// Data-memory bus between the LSU (master) and memory (slave).
// A valid/ready request channel plus a single-beat response / write-ack channel.
interface riscv_lsu_if #(parameter int DATA_WIDTH = 32);
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_we;
  logic [DATA_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic [3:0]            mem_req_wstrb;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_data;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/riscv_lsu.sv
// Load/store unit: one outstanding access, lane placement for stores,
// sign/zero extension for loads, faults for misalignment and bad funct3.
module riscv_lsu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  output logic                  lsu_done,
  output logic                  lsu_fault,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  riscv_lsu_if.master           mem
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e                state_q;
  logic                  done_q, fault_q, req_valid_q, we_q;
  logic [1:0]            off_q;
  logic [2:0]            f3_q;
  logic [3:0]            wstrb_q;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q, rdata_q;

  logic                  is_acc, is_st, bad_f3, misal;
  logic [3:0]            wstrb_d;
  logic [DATA_WIDTH-1:0] wdata_d, ext_d;
  logic [7:0]            rbyte;
  logic [15:0]           rhalf;

  assign is_acc = mem_read | mem_write;
  assign is_st  = mem_write;
  assign bad_f3 = is_st ? (funct3 > 3'd2)
                        : (funct3 == 3'd3 || funct3[2:1] == 2'b11);
  assign misal  = (funct3[1:0] == 2'd1 && lsu_addr[0]) ||
                  (funct3[1:0] == 2'd2 && lsu_addr[1:0] != 2'd0);

  // Store data is replicated so the memory only needs the strobes to pick lanes.
  always_comb begin
    wstrb_d = 4'b0000;
    wdata_d = lsu_wdata;
    case (funct3[1:0])
      2'd0: begin
        wstrb_d = 4'b0001 << lsu_addr[1:0];
        wdata_d = {4{lsu_wdata[7:0]}};
      end
      2'd1: begin
        wstrb_d = lsu_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{lsu_wdata[15:0]}};
      end
      default: wstrb_d = 4'b1111;
    endcase
    if (!is_st) wstrb_d = 4'b0000;
  end

  assign rbyte = 8'(mem.mem_resp_data >> {off_q, 3'b000});
  assign rhalf = off_q[1] ? mem.mem_resp_data[31:16] : mem.mem_resp_data[15:0];

  always_comb begin
    ext_d = mem.mem_resp_data;
    case (f3_q)
      3'b000:  ext_d = {{24{rbyte[7]}}, rbyte};
      3'b001:  ext_d = {{16{rhalf[15]}}, rhalf};
      3'b100:  ext_d = {24'd0, rbyte};
      3'b101:  ext_d = {16'd0, rhalf};
      default: ext_d = mem.mem_resp_data;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      req_valid_q <= 1'b0;
      we_q        <= 1'b0;
      off_q       <= 2'd0;
      f3_q        <= 3'd0;
      wstrb_q     <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        IDLE: if (lsu_valid && is_acc) begin
          off_q   <= lsu_addr[1:0];
          f3_q    <= funct3;
          we_q    <= is_st;
          addr_q  <= {lsu_addr[DATA_WIDTH-1:2], 2'b00};
          wdata_q <= wdata_d;
          wstrb_q <= wstrb_d;
          if (bad_f3 || misal) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            fault_q <= 1'b1;
            rdata_q <= '0;
          end else begin
            state_q     <= REQ;
            req_valid_q <= 1'b1;
          end
        end
        REQ: if (mem.mem_req_ready) begin
          req_valid_q <= 1'b0;
          state_q     <= WAIT;
        end
        WAIT: if (mem.mem_resp_valid) begin
          rdata_q <= we_q ? '0 : ext_d;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lsu_ready         = (state_q == IDLE);
  assign lsu_done          = done_q;
  assign lsu_fault         = fault_q;
  assign lsu_rdata         = rdata_q;
  assign mem.mem_req_valid = req_valid_q;
  assign mem.mem_req_we    = we_q;
  assign mem.mem_req_addr  = addr_q;
  assign mem.mem_req_wdata = wdata_q;
  assign mem.mem_req_wstrb = wstrb_q;
endmodule

// File: tb/tb_riscv_lsu.sv
// Randomized bench for riscv_lsu against an arithmetic reference model,
// plus the directed cases: extension, lane placement, faults, stalls, reset.
module tb_riscv_lsu;
  logic        clk = 1'b0, rst = 1'b1;
  logic        lsu_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] lsu_addr = '0, lsu_wdata = '0;
  logic        lsu_ready, lsu_done, lsu_fault;
  logic [31:0] lsu_rdata;
  int          n_chk = 0, n_err = 0;

  riscv_lsu_if #(.DATA_WIDTH(32)) bus ();

  riscv_lsu #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_done(lsu_done),
    .lsu_fault(lsu_fault), .lsu_rdata(lsu_rdata), .mem(bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic over byte offsets.
  function automatic bit m_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int sz = f3 % 4;
    if (st ? (f3 > 2) : (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
    if (sz == 1 && a % 2 != 0) return 1'b1;
    if (sz == 2 && a % 4 != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_strb(input bit st, input logic [2:0] f3, input logic [31:0] a);
    if (!st) return 0;
    case (f3 % 4)
      0: return 32'd1 << (a % 4);
      1: return 32'd3 << (a % 4 / 2 * 2);
      default: return 32'd15;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3 % 4)
      0: return (d % 256) * 32'h01010101;
      1: return (d % 65536) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_rdata(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) % 256;
    h = (w >> (8 * (a % 4 / 2 * 2))) % 65536;
    case (f3)
      0: return (b >= 128) ? b - 256 : b;
      1: return (h >= 32768) ? h - 65536 : h;
      4: return b;
      5: return h;
      default: return w;
    endcase
  endfunction

  task automatic issue(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    chk("ready_idle", 32'(lsu_ready), 1);
    lsu_valid = 1'b1; mem_read = rd; mem_write = wr;
    funct3 = f3; lsu_addr = a; lsu_wdata = wd;
    @(negedge clk);
    lsu_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    lsu_addr = $urandom; lsu_wdata = $urandom; funct3 = 3'($urandom);
  endtask

  task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rsp,
                        input int rdly, input int pdly, input bit stray);
    bit st = wr;
    issue(rd, wr, f3, a, wd);
    if (m_fault(st, f3, a)) begin
      chk("flt_done", 32'(lsu_done), 1);
      chk("flt_fault", 32'(lsu_fault), 1);
      chk("flt_noreq", 32'(bus.mem_req_valid), 0);
      @(negedge clk);
      chk("flt_done_clr", 32'(lsu_done), 0);
      chk("flt_fault_clr", 32'(lsu_fault), 0);
      return;
    end
    for (int k = 0; k <= rdly; k++) begin
      chk("req_valid", 32'(bus.mem_req_valid), 1);
      chk("req_addr", bus.mem_req_addr, a & 32'hFFFF_FFFC);
      chk("req_we", 32'(bus.mem_req_we), 32'(st));
      chk("req_wstrb", 32'(bus.mem_req_wstrb), m_strb(st, f3, a));
      if (st) chk("req_wdata", bus.mem_req_wdata, m_wdata(f3, wd));
      chk("req_busy", 32'(lsu_ready), 0);
      chk("req_nodone", 32'(lsu_done), 0);
      bus.mem_req_ready  = (k == rdly);
      bus.mem_resp_valid = stray && (k < rdly);
      bus.mem_resp_data  = $urandom;
      @(negedge clk);
    end
    bus.mem_req_ready = 1'b0;
    for (int k = 0; k <= pdly; k++) begin
      chk("wait_noreq", 32'(bus.mem_req_valid), 0);
      chk("wait_nodone", 32'(lsu_done), 0);
      chk("wait_busy", 32'(lsu_ready), 0);
      bus.mem_resp_valid = (k == pdly);
      bus.mem_resp_data  = (k == pdly) ? rsp : $urandom;
      @(negedge clk);
    end
    bus.mem_resp_valid = stray;
    bus.mem_resp_data  = $urandom;
    chk("done", 32'(lsu_done), 1);
    chk("done_fault", 32'(lsu_fault), 0);
    if (!st) chk("rdata", lsu_rdata, m_rdata(f3, a, rsp));
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    chk("done_pulse", 32'(lsu_done), 0);
    chk("back_idle", 32'(lsu_ready), 1);
  endtask

  initial begin
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_done", 32'(lsu_done), 0);
    chk("rst_reqv", 32'(bus.mem_req_valid), 0);
    chk("rst_wstrb", 32'(bus.mem_req_wstrb), 0);
    chk("rst_rdata", lsu_rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(lsu_ready), 1);

    // valid without read/write is ignored
    issue(1'b0, 1'b0, 3'd2, 32'h80000000, 0);
    chk("nop_ready", 32'(lsu_ready), 1);
    chk("nop_nodone", 32'(lsu_done), 0);

    run_op(1, 0, 3'b010, 32'h80000104, 0, 32'hDEADBEEF, 0, 0, 0);
    run_op(1, 0, 3'b000, 32'h80000003, 0, 32'h80FF7F01, 0, 0, 0);
    run_op(1, 0, 3'b100, 32'h80000003, 0, 32'h80FF7F01, 1, 0, 0);
    run_op(1, 0, 3'b001, 32'h80000002, 0, 32'h80FF7F01, 0, 1, 0);
    run_op(0, 1, 3'b000, 32'h80000002, 32'h000000A5, 0, 0, 0, 0);
    run_op(0, 1, 3'b001, 32'h80000002, 32'h00001234, 0, 1, 2, 0);
    run_op(1, 1, 3'b010, 32'h80000010, 32'hCAFEF00D, 0, 0, 0, 0);
    run_op(1, 0, 3'b010, 32'h80000001, 0, 0, 0, 0, 0);
    run_op(0, 1, 3'b001, 32'h80000003, 32'h1234, 0, 0, 0, 0);
    run_op(1, 0, 3'b011, 32'h80000000, 0, 0, 0, 0, 0);
    run_op(0, 1, 3'b100, 32'h80000000, 0, 0, 0, 0, 0);
    run_op(1, 0, 3'b101, 32'h80000002, 0, 32'h9ABC1234, 5, 4, 1);

    // async reset in WAIT, then a late response must be ignored
    issue(1, 0, 3'b010, 32'h80000200, 0);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", 32'(lsu_ready), 1);
    chk("arst_rdata", lsu_rdata, 0);
    chk("arst_addr", bus.mem_req_addr, 0);
    chk("arst_done", 32'(lsu_done), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h11111111;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    chk("late_nodone", 32'(lsu_done), 0);
    chk("late_ready", 32'(lsu_ready), 1);

    // async reset during REQ drops mem_req_valid without a clock edge
    issue(0, 1, 3'b010, 32'h80000300, 32'h55AA55AA);
    chk("req_pre_rst", 32'(bus.mem_req_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_reqv", 32'(bus.mem_req_valid), 0);
    chk("arst_we", 32'(bus.mem_req_we), 0);
    chk("arst_wstrb", 32'(bus.mem_req_wstrb), 0);
    chk("arst_wdata", bus.mem_req_wdata, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(1, 0, 3'b010, 32'h80000400, 0, 32'h0BADF00D, 0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      int          kind = $urandom_range(0, 2);
      logic [31:0] a    = $urandom;
      if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
      if ($urandom_range(0, 2) != 0) a[1] = 1'b0;
      run_op(kind != 1, kind != 0, 3'($urandom), a, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
